// File: rtl/riscof_sim_pkg.sv
// riscof_sim_pkg: shared status/state encodings for the riscof simulation sequencer
package riscof_sim_pkg;
  localparam int STATUS_W = 3;
  typedef enum logic [STATUS_W-1:0] {
    ST_NONE     = 3'd0,
    ST_PASS     = 3'd1,
    ST_FAIL     = 3'd2,
    ST_EXIT_OK  = 3'd3,
    ST_EXIT_ERR = 3'd4,
    ST_TIMEOUT  = 3'd5
  } status_e;
  typedef enum logic [2:0] {
    S_HOLD,
    S_FETCH_WAIT,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;
endpackage

// File: rtl/riscof_sim_cnt.sv
// riscof_sim_cnt: loadable down-counter that parks at zero and flags it
//   clk_i      clock
//   load_i     load load_val_i (wins over en_i)
//   en_i       decrement while nonzero
//   load_val_i value to load
//   zero_o     counter is zero
module riscof_sim_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i) begin
    cnt_q <= load_i ? load_val_i : (en_i && |cnt_q) ? cnt_q - W'(1) : cnt_q;
  end
  assign zero_o = ~|cnt_q;
endmodule

// File: rtl/riscof_sim_ctrl.sv
// riscof_sim_ctrl: core reset/fetch sequencer with watchdog, sticky status capture and drain window
//   clk_i, rst_ni   clock, synchronous active-low reset
//   max_cycles_i    watchdog limit in RUN cycles (0 = unlimited)
//   tests_passed_i, tests_failed_i, exit_valid_i, exit_value_i   events from the tb wrapper
//   core_rst_no, fetch_enable_o   core control to the tb wrapper
//   heartbeat_o     periodic one-cycle pulse while running
//   cycle_cnt_o     saturating count of completed RUN cycles
//   done_o, status_o, exit_value_o   sticky result
module riscof_sim_ctrl
  import riscof_sim_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = 8,
  parameter int unsigned FETCH_DELAY     = 4,
  parameter int unsigned DRAIN_CYCLES    = 16,
  parameter int unsigned HEARTBEAT       = 10000,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [CNT_WIDTH-1:0] max_cycles_i,
  input  logic                 tests_passed_i,
  input  logic                 tests_failed_i,
  input  logic                 exit_valid_i,
  input  logic [31:0]          exit_value_i,
  output logic                 core_rst_no,
  output logic                 fetch_enable_o,
  output logic                 heartbeat_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic                 done_o,
  output logic [STATUS_W-1:0]  status_o,
  output logic [31:0]          exit_value_o
);
  localparam logic SKIP_DRAIN = DRAIN_CYCLES == 0;
  localparam logic HB_EN = HEARTBEAT != 0;
  localparam logic [31:0] HOLD_LD = RST_HOLD_CYCLES - 1;
  localparam logic [31:0] FETCH_LD = FETCH_DELAY - 1;
  localparam logic [31:0] DRAIN_LD = SKIP_DRAIN ? 32'd0 : DRAIN_CYCLES - 1;
  localparam logic [31:0] HB_LD = HB_EN ? HEARTBEAT - 1 : 32'd0;
  state_e               state_q, state_d;
  status_e              status_q, status_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH:0]   cnt_inc;
  logic [31:0]          exit_q, ph_val, hb_val;
  logic                 core_rst_q, fetch_q, hb_q, done_q;
  logic                 run, timeout, ph_load, ph_zero, hb_load, hb_zero;
  assign run = state_q == S_RUN;
  // One bit wider so the watchdog compare still works once the count saturates.
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
  // >= rather than == so a limit lowered below the current count still trips.
  assign timeout = |max_cycles_i && cnt_inc >= {1'b0, max_cycles_i};
  always_comb begin
    status_d = tests_failed_i                   ? ST_FAIL     :
               (exit_valid_i && |exit_value_i)  ? ST_EXIT_ERR :
               exit_valid_i                     ? ST_EXIT_OK  :
               tests_passed_i                   ? ST_PASS     :
               timeout                          ? ST_TIMEOUT  : ST_NONE;
  end
  always_comb begin
    state_d = state_q == S_HOLD       ? (ph_zero ? S_FETCH_WAIT : S_HOLD) :
              state_q == S_FETCH_WAIT ? (ph_zero ? S_RUN : S_FETCH_WAIT) :
              state_q == S_RUN        ? (status_d == ST_NONE ? S_RUN : SKIP_DRAIN ? S_DONE : S_DRAIN) :
              state_q == S_DRAIN      ? (ph_zero ? S_DONE : S_DRAIN) : S_DONE;
  end
  // The phase timer is shared by HOLD, FETCH_WAIT and DRAIN; each entry reloads it.
  assign ph_load = !rst_ni || (state_q == S_HOLD && ph_zero) || (run && state_d == S_DRAIN);
  assign ph_val  = !rst_ni ? HOLD_LD : run ? DRAIN_LD : FETCH_LD;
  assign hb_load = !rst_ni || (state_d == S_RUN && (!run || hb_zero));
  assign hb_val  = rst_ni ? HB_LD : 32'd0;
  riscof_sim_cnt #(.W(32)) u_phase (
    .clk_i      (clk_i),
    .load_i     (ph_load),
    .en_i       (1'b1),
    .load_val_i (ph_val),
    .zero_o     (ph_zero)
  );
  riscof_sim_cnt #(.W(32)) u_heartbeat (
    .clk_i      (clk_i),
    .load_i     (hb_load),
    .en_i       (run),
    .load_val_i (hb_val),
    .zero_o     (hb_zero)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_HOLD;
      core_rst_q <= 1'b0;
      fetch_q    <= 1'b0;
      done_q     <= 1'b0;
      hb_q       <= 1'b0;
      cnt_q      <= '0;
      status_q   <= ST_NONE;
      exit_q     <= '0;
    end else begin
      state_q    <= state_d;
      core_rst_q <= state_d != S_HOLD;
      fetch_q    <= state_d == S_RUN || state_d == S_DRAIN;
      done_q     <= state_d == S_DONE;
      hb_q       <= HB_EN && run && state_d == S_RUN && hb_zero;
      if (run)
        cnt_q <= &cnt_q ? cnt_q : cnt_inc[CNT_WIDTH-1:0];
      else if (state_d == S_RUN)
        cnt_q <= '0;
      if (run && status_d != ST_NONE) begin
        status_q <= status_d;
        exit_q   <= (status_d == ST_EXIT_OK || status_d == ST_EXIT_ERR) ? exit_value_i : '0;
      end
    end
  end
  assign core_rst_no    = core_rst_q;
  assign fetch_enable_o = fetch_q;
  assign heartbeat_o    = hb_q;
  assign cycle_cnt_o    = cnt_q;
  assign done_o         = done_q;
  assign status_o       = status_q;
  assign exit_value_o   = exit_q;
endmodule

// File: tb/tb_riscof_sim_ctrl.sv
// tb_riscof_sim_ctrl: self-checking bench for riscof_sim_ctrl against a timeline model
module tb_riscof_sim_ctrl;
  localparam int HOLD = 8, FD = 4, DR = 16, HB = 10;
  logic        clk_i = 0, rst_ni = 0;
  logic        tests_passed_i = 0, tests_failed_i = 0, exit_valid_i = 0;
  logic [31:0] max_cycles_i = 0, exit_value_i = 0;
  logic        core_rst_no, fetch_enable_o, heartbeat_o, done_o;
  logic [31:0] cycle_cnt_o, exit_value_o;
  logic [2:0]  status_o;
  int n_chk = 0, n_pass = 0;
  always #5 clk_i = ~clk_i;
  riscof_sim_ctrl #(
    .RST_HOLD_CYCLES (HOLD),
    .FETCH_DELAY     (FD),
    .DRAIN_CYCLES    (DR),
    .HEARTBEAT       (HB),
    .CNT_WIDTH       (32)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .max_cycles_i   (max_cycles_i),
    .tests_passed_i (tests_passed_i),
    .tests_failed_i (tests_failed_i),
    .exit_valid_i   (exit_valid_i),
    .exit_value_i   (exit_value_i),
    .core_rst_no    (core_rst_no),
    .fetch_enable_o (fetch_enable_o),
    .heartbeat_o    (heartbeat_o),
    .cycle_cnt_o    (cycle_cnt_o),
    .done_o         (done_o),
    .status_o       (status_o),
    .exit_value_o   (exit_value_o)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // Timeline model: rel counts clock edges since reset release; the run starts
  // after HOLD+FD edges and everything else follows from when the run ended.
  int          rel = 0, term_at = 0;
  bit          term = 0, mv = 0, m_hb = 0;
  logic [31:0] m_cnt = 0, m_exit = 0;
  int          m_status = 0;
  always @(posedge clk_i) begin
    int st;
    if (!rst_ni) begin
      rel = 0; term = 0; term_at = 0; m_cnt = 0; m_status = 0; m_exit = 0; m_hb = 0; mv = 1;
    end else if (mv) begin
      m_hb = 0;
      if (rel >= HOLD + FD && !term) begin
        if (tests_failed_i) st = 2;
        else if (exit_valid_i && exit_value_i != 0) st = 4;
        else if (exit_valid_i) st = 3;
        else if (tests_passed_i) st = 1;
        else if (max_cycles_i != 0 && longint'(m_cnt) + 1 >= longint'(max_cycles_i)) st = 5;
        else st = 0;
        if (m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 1;
        if (st != 0) begin
          term = 1; term_at = rel + 1; m_status = st;
          m_exit = (st == 3 || st == 4) ? exit_value_i : 32'd0;
        end else if (m_cnt % HB == 0) m_hb = 1;
      end
      rel++;
    end
  end
  always @(negedge clk_i) begin
    if (mv) begin
      bit dn;
      dn = term && rel >= term_at + DR;
      chk("core_rst_no", core_rst_no, rel >= HOLD);
      chk("fetch_enable", fetch_enable_o, rel >= HOLD + FD && !dn);
      chk("done", done_o, dn);
      chk("heartbeat", heartbeat_o, m_hb);
      chk("cycle_cnt", cycle_cnt_o, m_cnt);
      chk("status", status_o, m_status);
      chk("exit_value", exit_value_o, m_exit);
    end
  end
  task automatic start();
    rst_ni = 0; tests_passed_i = 0; tests_failed_i = 0; exit_valid_i = 0; exit_value_i = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
  endtask
  task automatic wait_run();
    int n = 0;
    while (!fetch_enable_o && n < 100) begin @(negedge clk_i); n++; end
    chk("wait_run", fetch_enable_o, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int n, hbs, hsum;
    start();
    n = 0;
    while (!core_rst_no && n < 100) begin @(negedge clk_i); n++; end
    chk("core_rst_rise", n, 8);
    while (!fetch_enable_o && n < 100) begin @(negedge clk_i); n++; end
    chk("fetch_rise", n, 12);
    chk("cnt_at_run", cycle_cnt_o, 0);
    n = 0;
    while (cycle_cnt_o != 100 && n < 500) begin @(negedge clk_i); n++; end
    tests_passed_i = 1;
    @(negedge clk_i);
    tests_passed_i = 0;
    chk("pass_status", status_o, 1);
    chk("pass_cnt", cycle_cnt_o, 101);
    repeat (15) @(negedge clk_i);
    chk("done_early", done_o, 0);
    @(negedge clk_i);
    chk("done_at_16", done_o, 1);
    chk("fetch_off", fetch_enable_o, 0);
    chk("cnt_frozen", cycle_cnt_o, 101);
    start(); wait_run();
    repeat (3) @(negedge clk_i);
    exit_valid_i = 1; exit_value_i = 7; tests_passed_i = 1;
    @(negedge clk_i);
    exit_valid_i = 0; exit_value_i = 0; tests_passed_i = 0;
    chk("exit_err_status", status_o, 4);
    chk("exit_err_value", exit_value_o, 7);
    start(); wait_run();
    repeat (3) @(negedge clk_i);
    exit_valid_i = 1; exit_value_i = 7; tests_passed_i = 1; tests_failed_i = 1;
    @(negedge clk_i);
    exit_valid_i = 0; exit_value_i = 0; tests_passed_i = 0; tests_failed_i = 0;
    chk("fail_status", status_o, 2);
    chk("fail_value", exit_value_o, 0);
    start(); wait_run();
    repeat (2) @(negedge clk_i);
    exit_valid_i = 1; exit_value_i = 0;
    @(negedge clk_i);
    exit_valid_i = 0;
    chk("exit_ok_status", status_o, 3);
    max_cycles_i = 50;
    start(); wait_run();
    n = 0;
    while (status_o == 0 && n < 200) begin @(negedge clk_i); n++; end
    chk("timeout_status", status_o, 5);
    chk("timeout_cnt", cycle_cnt_o, 50);
    chk("timeout_cycles", n, 50);
    max_cycles_i = 0;
    start(); wait_run();
    repeat (2000) @(negedge clk_i);
    chk("no_timeout_status", status_o, 0);
    chk("no_timeout_cnt", cycle_cnt_o, 2000);
    max_cycles_i = 30;
    @(negedge clk_i);
    chk("lowered_limit", status_o, 5);
    max_cycles_i = 0;
    start(); wait_run();
    hbs = 0; hsum = 0;
    for (int i = 0; i < 35; i++) begin
      if (heartbeat_o) begin hbs++; hsum += int'(cycle_cnt_o); end
      @(negedge clk_i);
    end
    chk("hb_count", hbs, 3);
    chk("hb_sum", hsum, 60);
    start(); wait_run();
    repeat (5) @(negedge clk_i);
    tests_passed_i = 1;
    @(negedge clk_i);
    tests_passed_i = 0;
    repeat (5) @(negedge clk_i);
    chk("drain_fetch", fetch_enable_o, 1);
    chk("drain_done", done_o, 0);
    rst_ni = 0; tests_failed_i = 1;
    @(negedge clk_i);
    chk("rst_outputs", {core_rst_no, fetch_enable_o, heartbeat_o, done_o, status_o}, 0);
    chk("rst_cnt", cycle_cnt_o, 0);
    chk("rst_exit", exit_value_o, 0);
    rst_ni = 1;
    n = 0;
    while (!core_rst_no && n < 100) begin @(negedge clk_i); n++; end
    tests_failed_i = 0;
    chk("replay_core_rst", n, 8);
    while (!fetch_enable_o && n < 100) begin @(negedge clk_i); n++; end
    chk("replay_fetch", n, 12);
    repeat (3) @(negedge clk_i);
    chk("hold_fail_ignored", status_o, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
